bus_timer: RTL



---
 rtl/bus_timer_if.sv | 14 +
 rtl/bus_timer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/bus_timer_if.sv
// CPU data-bus port bundle for the timer peripheral: write/read strobes, offsets, data.
// Latency: none here; rdata is registered inside the slave one cycle after rd.
// Backpressure: none; the bus issues at most one write and one read per cycle.
interface bus_timer_if;
  logic        wr;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        rd;
  logic [31:0] raddr;
  logic [31:0] rdata;

  modport master (output wr, waddr, wdata, rd, raddr, input rdata);
  modport slave  (input wr, waddr, wdata, rd, raddr, output rdata);
endinterface

// File: rtl/bus_timer.sv
// Memory-mapped 32-bit timer: prescaler, compare match with sticky flag, auto-reload, level irq.
// Latency: writes take effect on the strobed edge; rdata is registered one cycle after rd.
// Backpressure: none; one write and one read accepted every cycle, never stalled.
module bus_timer #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic        clk,
  input  logic        rstn,
  bus_timer_if.slave  bus,
  output logic        timer_irq
);

  localparam int IW = ADDR_WIDTH - 2;
  localparam logic [IW-1:0] REG_CTRL  = IW'(0);
  localparam logic [IW-1:0] REG_PRESC = IW'(1);
  localparam logic [IW-1:0] REG_CMP   = IW'(2);
  localparam logic [IW-1:0] REG_STAT  = IW'(3);
  localparam logic [IW-1:0] REG_COUNT = IW'(4);

  logic          en, arl, ie;
  logic [15:0]   prescale;
  logic [15:0]   presc;
  logic [31:0]   compare;
  logic [31:0]   count;
  logic          flag;

  logic [IW-1:0] widx, ridx;
  logic          wr_ctrl, wr_presc, wr_cmp, wr_stat, wr_count;
  logic          clr, tick, match;
  logic [31:0]   rd_mux;

  // Byte lanes and bits above the offset window are decoded by the interconnect.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.waddr[31:ADDR_WIDTH], bus.waddr[1:0],
                              bus.raddr[31:ADDR_WIDTH], bus.raddr[1:0]};

  assign widx     = bus.waddr[ADDR_WIDTH-1:2];
  assign ridx     = bus.raddr[ADDR_WIDTH-1:2];
  assign wr_ctrl  = bus.wr && (widx == REG_CTRL);
  assign wr_presc = bus.wr && (widx == REG_PRESC);
  assign wr_cmp   = bus.wr && (widx == REG_CMP);
  assign wr_stat  = bus.wr && (widx == REG_STAT);
  assign wr_count = bus.wr && (widx == REG_COUNT);

  assign clr   = wr_ctrl && bus.wdata[2];
  assign tick  = en && (presc == prescale);
  assign match = tick && (count == compare);

  assign timer_irq = flag & ie;

  // Control and configuration registers; clr is a pulse and is never stored.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en       <= 1'b0;
      arl      <= 1'b0;
      ie       <= 1'b0;
      prescale <= 16'h0;
      compare  <= 32'hFFFF_FFFF;
    end else begin
      if (wr_ctrl) begin
        en  <= bus.wdata[0];
        arl <= bus.wdata[1];
        ie  <= bus.wdata[3];
      end
      if (wr_presc) prescale <= bus.wdata[15:0];
      if (wr_cmp)   compare  <= bus.wdata;
    end
  end

  // Prescaler: restarts on clr or COUNT load, wraps on tick, frozen while disabled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc <= 16'h0;
    end else if (clr || wr_count || tick) begin
      presc <= 16'h0;
    end else if (en) begin
      presc <= presc + 16'h1;
    end
  end

  // COUNT update with priority clr > bus load > tick.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= 32'h0;
    end else if (clr) begin
      count <= 32'h0;
    end else if (wr_count) begin
      count <= bus.wdata;
    end else if (tick) begin
      count <= (match && arl) ? 32'h0 : count + 32'h1;
    end
  end

  // Sticky match flag; a match in the same cycle beats a W1C clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      flag <= 1'b0;
    end else if (match) begin
      flag <= 1'b1;
    end else if (wr_stat && bus.wdata[0]) begin
      flag <= 1'b0;
    end
  end

  // Read mux over the pre-write register values; unmapped offsets read zero.
  always_comb begin
    rd_mux = 32'h0;
    case (ridx)
      REG_CTRL:  rd_mux = {28'h0, ie, 1'b0, arl, en};
      REG_PRESC: rd_mux = {16'h0, prescale};
      REG_CMP:   rd_mux = compare;
      REG_STAT:  rd_mux = {31'h0, flag};
      REG_COUNT: rd_mux = count;
      default:   rd_mux = 32'h0;
    endcase
  end

  // Registered read return; idle cycles drive zero so the interconnect can OR returns.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.rdata <= 32'h0;
    end else begin
      bus.rdata <= bus.rd ? rd_mux : 32'h0;
    end
  end

endmodule
